jtag_debug_cmd_sync: RTL and testbench

JTAG_DEBUG_CMD_SYNC -- requirements
Module: jtag_debug_cmd_sync

---
 rtl/jtag_debug_pkg.sv | 16 +
 rtl/jtag_debug_cmd_fifo.sv | 53 +++++
 rtl/jtag_debug_cmd_sync.sv | 118 +++++++++++
 tb/tb_jtag_debug_cmd_sync.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_debug_pkg.sv
// Shared constants and the default-width command entry for the JTAG debug command path.
package jtag_debug_pkg;

  localparam int unsigned DEF_DATA_W      = 38;
  localparam int unsigned DEF_IR_W        = 2;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_ACT_BIT     = 35;
  localparam int unsigned OVF_CNT_W       = 8;

  typedef struct packed {
    logic [DEF_IR_W-1:0]   ir;
    logic [DEF_DATA_W-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/jtag_debug_cmd_fifo.sv
// Command FIFO: registered storage, wrapping pointers and an occupancy counter.
module jtag_debug_cmd_fifo #(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// Synchronises JTAG update-DR into clk, queues {ir, data} commands and decodes action pulses.
// Optional macro JTAG_DEBUG_CMD_OVF_CNT_EN adds the saturating dropped-command counter.
module jtag_debug_cmd_sync
  import jtag_debug_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned IR_W        = DEF_IR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned ACT_BIT     = DEF_ACT_BIT,
  parameter int unsigned NUM_IR      = 2 ** IR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vs_udr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DATA_W-1:0]    sr,
  input  logic                 cmd_ready,
  input  logic                 ovf_clr,
  output logic                 cmd_valid,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DATA_W-1:0]    jdo,
  output logic [NUM_IR-1:0]    take_action,
  output logic [NUM_IR-1:0]    take_no_action,
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   armed;
  logic                   edge_q;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   full;
  logic                   drop;
  entry_t                 wr_entry;
  entry_t                 head;

  // armed only follows samples that really came from vs_udr, so a level held through reset never pushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      sync_vld <= '0;
      armed    <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], vs_udr};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      if (sync_vld[SYNC_STAGES-1]) armed <= ~sync_q[SYNC_STAGES-1];
      edge_q   <= sync_vld[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & armed;
    end
  end

  assign push     = edge_q;
  assign pop      = cmd_valid & cmd_ready;
  assign drop     = push & full & ~pop;
  assign wr_entry = '{ir: ir_in, data: sr};

  jtag_debug_cmd_fifo #(
    .W     (IR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign cmd_valid = ~empty;
  assign cmd_ir    = head.ir;
  assign jdo       = head.data;

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (jdo[ACT_BIT]) take_action[cmd_ir]    = 1'b1;
      else              take_no_action[cmd_ir] = 1'b1;
    end
  end

  // A drop on the same edge as a clear leaves the flag set and the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_clr) begin
      overflow <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef JTAG_DEBUG_CMD_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= OVF_CNT_W'(drop);
    end else if (drop && (ovf_count != '1)) begin
      ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed self-checking bench for jtag_debug_cmd_sync (default parameters).
module tb_jtag_debug_cmd_sync;
  import jtag_debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready;
  logic        ovf_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        overflow;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;
  cmd_entry_t exp_q[$];

`ifdef JTAG_DEBUG_CMD_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  jtag_debug_cmd_sync dut (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overflow       (overflow),
    .ovf_count      (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [37:0] mk(input logic act, input logic [7:0] tag);
    logic [37:0] v;
    v        = '0;
    v[7:0]   = tag;
    v[35]    = act;
    v[37]    = tag[0];
    return v;
  endfunction

  task automatic load(input logic [1:0] ir, input logic act, input logic [7:0] tag);
    ir_in = ir;
    sr    = mk(act, tag);
  endtask

  // Five-cycle update-DR pulse; the push lands four edges after the rise.
  task automatic pulse(input logic [1:0] ir, input logic act, input logic [7:0] tag);
    load(ir, act, tag);
    vs_udr = 1'b1;
    cyc(2);
    vs_udr = 1'b0;
    cyc(3);
  endtask

  task automatic queue_pulse(input logic [1:0] ir, input logic act, input logic [7:0] tag);
    cmd_entry_t e;
    e.ir   = ir;
    e.data = mk(act, tag);
    exp_q.push_back(e);
    pulse(ir, act, tag);
  endtask

  task automatic drain(input string tag);
    cmd_entry_t e;
    cmd_ready = 1'b1;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(cmd_valid), 64'(1));
      chk({tag, "_ir"}, 64'(cmd_ir), 64'(e.ir));
      chk({tag, "_jdo"}, 64'(jdo), 64'(e.data));
      chk({tag, "_act"}, 64'(take_action), e.data[35] ? 64'(4'b0001 << e.ir) : 64'(0));
      chk({tag, "_noact"}, 64'(take_no_action), e.data[35] ? 64'(0) : 64'(4'b0001 << e.ir));
      cyc(1);
      #1;
    end
    cmd_ready = 1'b0;
    #1;
    chk({tag, "_empty"}, 64'(cmd_valid), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    vs_udr    = 1'b0;
    ir_in     = '0;
    sr        = '0;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    cyc(3);
    reset = 1'b0;
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_act", 64'(take_action), 64'(0));
    chk("rst_noact", 64'(take_no_action), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_cnt", 64'(ovf_count), 64'(0));
    cyc(2);

    // Single command with latency check and a one-cycle take_action pulse.
    cmd_ready = 1'b1;
    load(2'b01, 1'b1, 8'h11);
    vs_udr = 1'b1;
    cyc(2);
    vs_udr = 1'b0;
    cyc(1);
    chk("lat_early", 64'(cmd_valid), 64'(0));
    cyc(1);
    chk("lat_valid", 64'(cmd_valid), 64'(1));
    chk("single_act", 64'(take_action), 64'(4'b0010));
    chk("single_noact", 64'(take_no_action), 64'(0));
    chk("single_jdo", 64'(jdo), 64'(mk(1'b1, 8'h11)));
    cyc(1);
    chk("single_gone", 64'(cmd_valid), 64'(0));
    chk("single_act_off", 64'(take_action), 64'(0));
    cyc(2);

    // No-action decode.
    load(2'b11, 1'b0, 8'h22);
    vs_udr = 1'b1;
    cyc(2);
    vs_udr = 1'b0;
    cyc(2);
    chk("noact_valid", 64'(cmd_valid), 64'(1));
    chk("noact_noact", 64'(take_no_action), 64'(4'b1000));
    chk("noact_act", 64'(take_action), 64'(0));
    cyc(3);
    cmd_ready = 1'b0;

    // Fill past capacity: fifth command dropped.
    queue_pulse(2'b00, 1'b1, 8'h30);
    queue_pulse(2'b01, 1'b0, 8'h31);
    queue_pulse(2'b10, 1'b1, 8'h32);
    queue_pulse(2'b11, 1'b0, 8'h33);
    chk("fill4_ovf", 64'(overflow), 64'(0));
    pulse(2'b10, 1'b0, 8'h34);
    chk("fill_ovf", 64'(overflow), 64'(1));
    chk("fill_cnt", 64'(ovf_count), CNT_EN ? 64'(1) : 64'(0));
    drain("fill");

    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'(0));
    chk("clr_cnt", 64'(ovf_count), 64'(0));

    // Full FIFO with push and pop on the same edge.
    queue_pulse(2'b00, 1'b0, 8'h40);
    queue_pulse(2'b01, 1'b1, 8'h41);
    queue_pulse(2'b10, 1'b0, 8'h42);
    queue_pulse(2'b11, 1'b1, 8'h43);
    load(2'b10, 1'b1, 8'h44);
    vs_udr = 1'b1;
    cyc(2);
    vs_udr = 1'b0;
    cyc(1);
    cmd_ready = 1'b1;
    #1;
    chk("pp_head_noact", 64'(take_no_action), 64'(4'b0001));
    cyc(1);
    cmd_ready = 1'b0;
    void'(exp_q.pop_front());
    begin
      cmd_entry_t e;
      e.ir   = 2'b10;
      e.data = mk(1'b1, 8'h44);
      exp_q.push_back(e);
    end
    chk("pp_ovf", 64'(overflow), 64'(0));
    cyc(1);
    drain("pp");

    // Saturation at 255, then clear racing a drop.
    for (int i = 0; i < 4; i++) pulse(2'b00, 1'b1, 8'(i));
    for (int i = 0; i < 300; i++) pulse(2'b01, 1'b0, 8'(i));
    chk("sat_ovf", 64'(overflow), 64'(1));
    chk("sat_cnt", 64'(ovf_count), CNT_EN ? 64'(255) : 64'(0));
    load(2'b11, 1'b1, 8'h55);
    vs_udr = 1'b1;
    cyc(2);
    vs_udr = 1'b0;
    cyc(1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("clrdrop_ovf", 64'(overflow), 64'(1));
    chk("clrdrop_cnt", 64'(ovf_count), CNT_EN ? 64'(1) : 64'(0));

    // Reset discards a full queue.
    do_reset();
    chk("rst2_valid", 64'(cmd_valid), 64'(0));
    chk("rst2_ovf", 64'(overflow), 64'(0));
    cyc(2);

    // Reset with three queued and vs_udr held high through it.
    pulse(2'b00, 1'b1, 8'h60);
    pulse(2'b01, 1'b1, 8'h61);
    pulse(2'b10, 1'b1, 8'h62);
    chk("q3_valid", 64'(cmd_valid), 64'(1));
    load(2'b11, 1'b1, 8'h63);
    vs_udr = 1'b1;
    cyc(1);
    do_reset();
    cyc(8);
    chk("held_valid", 64'(cmd_valid), 64'(0));
    chk("held_ovf", 64'(overflow), 64'(0));
    vs_udr = 1'b0;
    cyc(4);
    chk("low_valid", 64'(cmd_valid), 64'(0));
    queue_pulse(2'b10, 1'b1, 8'h70);
    drain("rearm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
